// File: rtl/rcb_ram_ctrl.sv
// rtl/rcb_ram_ctrl.sv - RCB lookup-table RAM controller, hpb write responder with lookup read priority
//
// Owns the single-port RAM holding one RCB's lookup table (symbol, price,
// volume or order). The lookup read path has priority on the RAM port. A
// host write from hpb is captured and then issued in the first cycle
// without an accepted read. Each host write completes with a one-cycle
// rcb_wr_done pulse.
//
// Optional build macro: RCB_WR_FORCE_EN
//   Defined   : after MAX_WR_STALL cycles of a pending write blocked by
//               reads, lkp_rd_ready drops for one cycle and the write goes.
//   Undefined : lkp_rd_ready is tied high. Continuous reads can hold off
//               a pending write for as long as they continue.
//
// Ports
//   clk             core clock
//   reset_n         asynchronous active-low reset
//   hpb_wr_req      level write request, held while hpb targets this RCB
//   hpb_wr_addr     write word address (HPB_ADDR_WIDTH bits)
//   hpb_wr_data     write data
//   hpb_wr_byte_en  per-byte write enable, bit i covers data[8i+7:8i]
//   rcb_wr_done     one-cycle pulse: write committed or dropped
//   rcb_wr_oor      one-cycle pulse with rcb_wr_done when address >= DEPTH
//   lkp_rd_req      lookup read request
//   lkp_rd_addr     lookup read address
//   lkp_rd_ready    read accepted when req and ready are both high
//   lkp_rd_valid    read data valid, one cycle after acceptance
//   lkp_rd_data     read data, holds its last value while valid is low

module rcb_ram_ctrl #(
  parameter int DATA_WIDTH     = 64,
  parameter int BE_WIDTH       = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH     = 10,
  parameter int DEPTH          = 1024,
  parameter int HPB_ADDR_WIDTH = 32,
  parameter int MAX_WR_STALL   = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      hpb_wr_req,
  input  logic [HPB_ADDR_WIDTH-1:0] hpb_wr_addr,
  input  logic [DATA_WIDTH-1:0]     hpb_wr_data,
  input  logic [BE_WIDTH-1:0]       hpb_wr_byte_en,
  output logic                      rcb_wr_done,
  output logic                      rcb_wr_oor,
  input  logic                      lkp_rd_req,
  input  logic [ADDR_WIDTH-1:0]     lkp_rd_addr,
  output logic                      lkp_rd_ready,
  output logic                      lkp_rd_valid,
  output logic [DATA_WIDTH-1:0]     lkp_rd_data
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_DONE,
    ST_HOLD
  } state_t;

  state_t                    state;
  logic [HPB_ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0]     cap_data;
  logic [BE_WIDTH-1:0]       cap_be;
  logic                      done_q;
  logic                      oor_q;
  logic                      rd_valid_q;
  logic [DATA_WIDTH-1:0]     rd_data_q;

  logic [DATA_WIDTH-1:0]     mem [DEPTH];

  logic                      rd_accept;
  logic                      wr_issue;
  logic                      cap_oor;
  logic                      ram_we;
  logic                      rd_in_range;
  logic                      tuple_diff;
  logic [ADDR_WIDTH-1:0]     ram_waddr;

  assign rd_accept = lkp_rd_req & lkp_rd_ready;

  // The port goes to the write only when no read was accepted this cycle.
  assign wr_issue  = (state == ST_PEND) & ~rd_accept;

  // The compare uses the full hpb address, so nonzero upper bits beyond
  // ADDR_WIDTH count as out of range. The extra MSB keeps the compare
  // correct when DEPTH equals 2**ADDR_WIDTH.
  assign cap_oor     = ({1'b0, cap_addr} >= (HPB_ADDR_WIDTH + 1)'(DEPTH));
  assign ram_we      = wr_issue & ~cap_oor;
  assign ram_waddr   = cap_addr[ADDR_WIDTH-1:0];
  assign rd_in_range = ({1'b0, lkp_rd_addr} < (ADDR_WIDTH + 1)'(DEPTH));

  // A new host message to this RCB may arrive without req dropping. A
  // change in any field of the live tuple marks it as a new write.
  assign tuple_diff = (hpb_wr_addr    != cap_addr) |
                      (hpb_wr_data    != cap_data) |
                      (hpb_wr_byte_en != cap_be);

  // Write handshake FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cap_addr <= '0;
      cap_data <= '0;
      cap_be   <= '0;
      done_q   <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      oor_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hpb_wr_req) begin
            cap_addr <= hpb_wr_addr;
            cap_data <= hpb_wr_data;
            cap_be   <= hpb_wr_byte_en;
            state    <= ST_PEND;
          end
        end
        // The captured tuple is committed. The write completes even if
        // req drops while it waits.
        ST_PEND: begin
          if (wr_issue) begin
            done_q <= 1'b1;
            oor_q  <= cap_oor;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!hpb_wr_req || tuple_diff) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Lookup read pipeline. The data register updates only on an accepted
  // read, so it holds its value between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) begin
        rd_data_q <= rd_in_range ? mem[lkp_rd_addr] : '0;
      end
    end
  end

  // RAM write port. RAM contents are not reset. A zero byte enable leaves
  // the word unchanged.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (cap_be[i]) begin
          mem[ram_waddr][8*i +: 8] <= cap_data[8*i +: 8];
        end
      end
    end
  end

`ifdef RCB_WR_FORCE_EN
  localparam int STALL_W = $clog2(MAX_WR_STALL + 1);

  logic [STALL_W-1:0] stall_cnt;
  logic               rd_ready_q;

  // Counts PEND cycles where a read took the port. On the cycle that
  // brings the count to MAX_WR_STALL, ready drops for the next cycle.
  // That cycle has no accepted read, so the write issues and the counter
  // clears when PEND is left.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt  <= '0;
      rd_ready_q <= 1'b1;
    end else if ((state == ST_PEND) && rd_accept) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
      if (stall_cnt == STALL_W'(MAX_WR_STALL - 1)) begin
        rd_ready_q <= 1'b0;
      end
    end else begin
      stall_cnt  <= '0;
      rd_ready_q <= 1'b1;
    end
  end

  assign lkp_rd_ready = rd_ready_q;
`else
  assign lkp_rd_ready = 1'b1;
`endif

  assign rcb_wr_done  = done_q;
  assign rcb_wr_oor   = oor_q;
  assign lkp_rd_valid = rd_valid_q;
  assign lkp_rd_data  = rd_data_q;

endmodule

// File: tb/tb_rcb_ram_ctrl.sv
// tb/tb_rcb_ram_ctrl.sv - self-checking bench for rcb_ram_ctrl
module tb_rcb_ram_ctrl;
  localparam int DW    = 64;
  localparam int BW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;
  localparam int HAW   = 32;
  localparam int MAXS  = 16;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           hpb_wr_req;
  logic [HAW-1:0] hpb_wr_addr;
  logic [DW-1:0]  hpb_wr_data;
  logic [BW-1:0]  hpb_wr_byte_en;
  logic           rcb_wr_done;
  logic           rcb_wr_oor;
  logic           lkp_rd_req;
  logic [AW-1:0]  lkp_rd_addr;
  logic           lkp_rd_ready;
  logic           lkp_rd_valid;
  logic [DW-1:0]  lkp_rd_data;

  int n_pass   = 0;
  int n_checks = 0;

  // The bench model covers words 0..15, the only in-range words used here.
  logic [DW-1:0] model [16];

  rcb_ram_ctrl #(
    .DATA_WIDTH(DW), .BE_WIDTH(BW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .HPB_ADDR_WIDTH(HAW), .MAX_WR_STALL(MAXS)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .hpb_wr_req(hpb_wr_req), .hpb_wr_addr(hpb_wr_addr),
    .hpb_wr_data(hpb_wr_data), .hpb_wr_byte_en(hpb_wr_byte_en),
    .rcb_wr_done(rcb_wr_done), .rcb_wr_oor(rcb_wr_oor),
    .lkp_rd_req(lkp_rd_req), .lkp_rd_addr(lkp_rd_addr),
    .lkp_rd_ready(lkp_rd_ready), .lkp_rd_valid(lkp_rd_valid),
    .lkp_rd_data(lkp_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < BW; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [HAW-1:0] wa, input logic [DW-1:0] wd,
                          input logic [BW-1:0] wbe, input logic exp_oor, output int lat);
    bit got;
    hpb_wr_req = 1'b1; hpb_wr_addr = wa; hpb_wr_data = wd; hpb_wr_byte_en = wbe;
    lat = 0; got = 0;
    while (!got && lat < 50) begin
      tick(); lat++;
      if (rcb_wr_done) got = 1;
    end
    n_checks++;
    if (!got) $display("FAIL wr_done_timeout addr=%h: got no done, required done", wa);
    else n_pass++;
    if (got) begin
      n_checks++;
      if (rcb_wr_oor !== exp_oor) $display("FAIL wr_oor addr=%h: got %b required %b", wa, rcb_wr_oor, exp_oor);
      else n_pass++;
      if (!exp_oor && wa < 16) model[wa[3:0]] = merge(model[wa[3:0]], wd, wbe);
    end
    hpb_wr_req = 1'b0;
    tick();
    n_checks++;
    if (rcb_wr_done !== 1'b0) $display("FAIL wr_done_single addr=%h: got %b required 0", wa, rcb_wr_done);
    else n_pass++;
    tick();
  endtask

  task automatic do_read(input int a, input logic [DW-1:0] exp);
    lkp_rd_req = 1'b1; lkp_rd_addr = AW'(a);
    tick();
    n_checks++;
    if (lkp_rd_valid !== 1'b1) $display("FAIL rd_valid addr=%0d: got %b required 1", a, lkp_rd_valid);
    else n_pass++;
    n_checks++;
    if (lkp_rd_data !== exp) $display("FAIL rd_data addr=%0d: got %h required %h", a, lkp_rd_data, exp);
    else n_pass++;
    lkp_rd_req = 1'b0;
    tick();
    n_checks++;
    if (lkp_rd_valid !== 1'b0) $display("FAIL rd_valid_drop addr=%0d: got %b required 0", a, lkp_rd_valid);
    else n_pass++;
    n_checks++;
    if (lkp_rd_data !== exp) $display("FAIL rd_data_hold addr=%0d: got %h required %h", a, lkp_rd_data, exp);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; hpb_wr_req = 0; hpb_wr_addr = '0; hpb_wr_data = '0; hpb_wr_byte_en = '0;
    lkp_rd_req = 0; lkp_rd_addr = '0;
    #12;
    n_checks++;
    if ({rcb_wr_done, rcb_wr_oor, lkp_rd_valid} !== 3'b000)
      $display("FAIL reset_flags: got %b required 000", {rcb_wr_done, rcb_wr_oor, lkp_rd_valid});
    else n_pass++;
    n_checks++;
    if (lkp_rd_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", lkp_rd_ready);
    else n_pass++;
    n_checks++;
    if (lkp_rd_data !== '0) $display("FAIL reset_data: got %h required 0", lkp_rd_data);
    else n_pass++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_preload();
    int lat;
    for (int i = 0; i < 16; i++) do_write(HAW'(i), rand64(), 8'hFF, 1'b0, lat);
  endtask

  task automatic test_basic_write();
    int lat;
    do_write(32'd5, 64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b0, lat);
    n_checks++;
    if (lat !== 2) $display("FAIL basic_latency: got %0d required 2", lat);
    else n_pass++;
    do_read(5, 64'hDEAD_BEEF_0123_4567);
  endtask

  task automatic test_byte_en();
    int lat;
    logic [DW-1:0] old;
    do_write(32'd7, '1, 8'hFF, 1'b0, lat);
    do_write(32'd7, '0, 8'h0F, 1'b0, lat);
    do_read(7, 64'hFFFF_FFFF_0000_0000);
    old = model[9];
    do_write(32'd9, rand64(), 8'h00, 1'b0, lat);
    do_read(9, old);
  endtask

  task automatic test_hold();
    int cnt;
    logic [DW-1:0] da, db;
    da = rand64(); db = ~da;
    hpb_wr_req = 1; hpb_wr_addr = 32'd3; hpb_wr_data = da; hpb_wr_byte_en = 8'hFF;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (rcb_wr_done) cnt++; end
    n_checks++;
    if (cnt !== 1) $display("FAIL hold_done_count_a: got %0d required 1", cnt);
    else n_pass++;
    hpb_wr_data = db;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (rcb_wr_done) cnt++; end
    n_checks++;
    if (cnt !== 1) $display("FAIL hold_done_count_b: got %0d required 1", cnt);
    else n_pass++;
    hpb_wr_req = 0;
    tick(); tick();
    model[3] = db;
    do_read(3, db);
  endtask

  task automatic test_oor();
    int lat;
    logic [DW-1:0] old;
    old = model[2];
    do_write(HAW'(DEPTH + 2), rand64(), 8'hFF, 1'b1, lat);
    n_checks++;
    if (lat !== 2) $display("FAIL oor_latency: got %0d required 2", lat);
    else n_pass++;
    do_read(2, old);
    do_write(32'h8000_0002, rand64(), 8'hFF, 1'b1, lat);
    do_read(2, old);
  endtask

  task automatic test_starve();
    int ready_low, first_low, done_at, done_cnt, lat;
    logic [DW-1:0] d;
    d = rand64();
    lkp_rd_req = 1; lkp_rd_addr = AW'(4);
    hpb_wr_req = 1; hpb_wr_addr = 32'd11; hpb_wr_data = d; hpb_wr_byte_en = 8'hFF;
    ready_low = 0; first_low = -1; done_at = -1; done_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (!lkp_rd_ready) begin ready_low++; if (first_low < 0) first_low = c; end
      if (rcb_wr_done) begin done_cnt++; if (done_at < 0) done_at = c; end
    end
`ifdef RCB_WR_FORCE_EN
    n_checks++;
    if (ready_low !== 1) $display("FAIL starve_ready_low_count: got %0d required 1", ready_low);
    else n_pass++;
    n_checks++;
    if (first_low !== MAXS + 1) $display("FAIL starve_ready_low_at: got %0d required %0d", first_low, MAXS + 1);
    else n_pass++;
    n_checks++;
    if (done_at !== MAXS + 2 || done_cnt !== 1)
      $display("FAIL starve_done: got at=%0d cnt=%0d required at=%0d cnt=1", done_at, done_cnt, MAXS + 2);
    else n_pass++;
    lkp_rd_req = 0;
`else
    n_checks++;
    if (ready_low !== 0) $display("FAIL starve_ready_low_count: got %0d required 0", ready_low);
    else n_pass++;
    n_checks++;
    if (done_cnt !== 0) $display("FAIL starve_done_early: got %0d required 0", done_cnt);
    else n_pass++;
    lkp_rd_req = 0;
    lat = 0;
    while (!rcb_wr_done && lat < 10) begin tick(); lat++; end
    n_checks++;
    if (!rcb_wr_done || lat !== 1) $display("FAIL starve_release_latency: got %0d required 1", lat);
    else n_pass++;
`endif
    hpb_wr_req = 0;
    tick(); tick();
    model[11] = d;
    do_read(11, d);
  endtask

  task automatic test_reset_mid();
    int lat, done_cnt;
    logic [DW-1:0] d;
    d = rand64();
    lkp_rd_req = 1; lkp_rd_addr = AW'(4);
    hpb_wr_req = 1; hpb_wr_addr = 32'd12; hpb_wr_data = d; hpb_wr_byte_en = 8'hFF;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (rcb_wr_done) done_cnt++; end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({rcb_wr_done, rcb_wr_oor, lkp_rd_valid, lkp_rd_ready} !== 4'b0001)
      $display("FAIL midreset_outputs: got %b required 0001",
               {rcb_wr_done, rcb_wr_oor, lkp_rd_valid, lkp_rd_ready});
    else n_pass++;
    n_checks++;
    if (lkp_rd_data !== '0) $display("FAIL midreset_data: got %h required 0", lkp_rd_data);
    else n_pass++;
    lkp_rd_req = 0;
    tick(); if (rcb_wr_done) done_cnt++;
    tick(); if (rcb_wr_done) done_cnt++;
    n_checks++;
    if (done_cnt !== 0) $display("FAIL midreset_no_done: got %0d required 0", done_cnt);
    else n_pass++;
    reset_n = 1'b1;
    lat = 0;
    while (!rcb_wr_done && lat < 10) begin tick(); lat++; end
    n_checks++;
    if (!rcb_wr_done || lat !== 2) $display("FAIL midreset_recapture_latency: got %0d required 2", lat);
    else n_pass++;
    hpb_wr_req = 0;
    tick(); tick();
    model[12] = d;
    do_read(12, d);
  endtask

  task automatic test_random();
    bit wr_active, hold_rd, r, acc, woor;
    int gap, wcyc, ra;
    logic [HAW-1:0] wa;
    logic [DW-1:0] wd, exp;
    logic [BW-1:0] wbe;
    wr_active = 0; hold_rd = 0; gap = 0; wcyc = 0; ra = 0;
    wa = '0; wd = '0; wbe = '0; woor = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!wr_active) begin
        if (gap > 0) gap--;
        else begin
          if ($urandom_range(0, 99) < 85) begin wa = HAW'($urandom_range(0, 15)); woor = 0; end
          else if ($urandom_range(0, 1) == 0) begin wa = HAW'(DEPTH + $urandom_range(0, 100)); woor = 1; end
          else begin wa = 32'h0001_0000 | HAW'($urandom_range(0, 15)); woor = 1; end
          wd = rand64();
          wbe = ($urandom_range(0, 9) == 0) ? 8'h00 : BW'($urandom);
          hpb_wr_req = 1; hpb_wr_addr = wa; hpb_wr_data = wd; hpb_wr_byte_en = wbe;
          wr_active = 1; wcyc = 0;
        end
      end
      if (!hold_rd) begin
        r = ($urandom_range(0, 99) < 60);
        ra = $urandom_range(0, 15);
      end
      lkp_rd_req = r; lkp_rd_addr = AW'(ra);
      acc = r && lkp_rd_ready;
      hold_rd = r && !lkp_rd_ready;
      exp = model[ra];
      tick();
      n_checks++;
      if (lkp_rd_valid !== acc) $display("FAIL rand_valid cyc=%0d: got %b required %b", c, lkp_rd_valid, acc);
      else n_pass++;
      if (acc) begin
        n_checks++;
        if (lkp_rd_data !== exp) $display("FAIL rand_data cyc=%0d addr=%0d: got %h required %h", c, ra, lkp_rd_data, exp);
        else n_pass++;
      end
      n_checks++;
      if (rcb_wr_done && lkp_rd_valid) $display("FAIL rand_port_conflict cyc=%0d: got done=1 valid=1 required not both", c);
      else n_pass++;
      if (wr_active) begin
        wcyc++;
        if (rcb_wr_done) begin
          n_checks++;
          if (rcb_wr_oor !== woor) $display("FAIL rand_oor cyc=%0d addr=%h: got %b required %b", c, wa, rcb_wr_oor, woor);
          else n_pass++;
          if (!woor) model[wa[3:0]] = merge(model[wa[3:0]], wd, wbe);
          hpb_wr_req = 0; wr_active = 0; gap = 2;
        end else if (wcyc > 200) begin
          n_checks++;
          $display("FAIL rand_wr_timeout cyc=%0d addr=%h: got no done, required done", c, wa);
          hpb_wr_req = 0; wr_active = 0; gap = 2;
        end
      end else begin
        n_checks++;
        if (rcb_wr_done !== 1'b0) $display("FAIL rand_spurious_done cyc=%0d: got %b required 0", c, rcb_wr_done);
        else n_pass++;
      end
    end
    lkp_rd_req = 0; hpb_wr_req = 0;
    tick(); tick(); tick();
    for (int i = 0; i < 16; i++) do_read(i, model[i]);
  endtask

  initial begin
    test_reset();
    test_preload();
    test_basic_write();
    test_byte_en();
    test_hold();
    test_oor();
    test_starve();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rcb_ram_ctrl.md
Name: rcb_ram_ctrl

Overview:
- Responder end of the hpb_if host-write channel, instantiated once per RCB (symbol, price, volume, order).
- Owns a single-port RAM that holds that RCB's lookup table. The lookup path reads it; host writes from hpb update it.
- Lookup reads get priority; host writes fill idle slots.
- Completes each host write with a one-cycle rcb_wr_done pulse.

Parameters:
- DATA_WIDTH, 64, RAM word width in bits (64 or 128).
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- ADDR_WIDTH, 10, RAM address width.
- DEPTH, 1024, number of implemented words, at most 2**ADDR_WIDTH.
- HPB_ADDR_WIDTH, 32, width of the incoming hpb_wr_addr.
- MAX_WR_STALL, 16, write-starvation limit in cycles (used only with RCB_WR_FORCE_EN).

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- hpb_wr_req  in  1  level write request from hpb; held high while hpb targets this RCB
- hpb_wr_addr  in  HPB_ADDR_WIDTH  write word address
- hpb_wr_data  in  DATA_WIDTH  write data
- hpb_wr_byte_en  in  BE_WIDTH  per-byte write enable, bit i covers data[8i+7:8i]
- rcb_wr_done  out  1  one-cycle pulse: write committed or dropped
- rcb_wr_oor  out  1  one-cycle pulse, coincident with rcb_wr_done, when the address was out of range
- lkp_rd_req  in  1  lookup read request
- lkp_rd_addr  in  ADDR_WIDTH  lookup read address
- lkp_rd_ready  out  1  read accepted this cycle
- lkp_rd_valid  out  1  read data valid
- lkp_rd_data  out  DATA_WIDTH  read data

Behaviour:
- Reset (async assert, sync deassert by the integrating top):
  - all outputs 0 except lkp_rd_ready=1; FSM to IDLE; stall counter 0.
  - RAM contents are not reset.
- Reads:
  - Accepted when lkp_rd_req & lkp_rd_ready.
  - lkp_rd_valid and lkp_rd_data are registered and appear exactly 1 cycle after acceptance. Fully pipelined, one read per cycle.
  - lkp_rd_data holds its last value while valid=0.
- The single RAM port serves either a read or a write in a given cycle. A write is never issued in a cycle with an accepted read.
- FSM states:
  - IDLE: if hpb_wr_req=1, capture {addr, data, byte_en} into a committed tuple and go to PEND.
  - PEND: in the first cycle where there is no accepted read, issue the RAM write with byte_en and go to DONE.
    - If hpb_wr_addr >= DEPTH (including any nonzero upper bits beyond ADDR_WIDTH), suppress the RAM write.
  - DONE: 1 cycle. Assert rcb_wr_done=1, and rcb_wr_oor=1 if the write was suppressed. Go to HOLD.
  - HOLD: wait for a new request. Go to IDLE when hpb_wr_req=0 or when the live {addr, data, byte_en} differs from the committed tuple. The differing case lets back-to-back host messages to the same RCB proceed without req dropping.
- Write-then-read ordering: a write committed in cycle N is visible to a read accepted in cycle N+1 or later.
- byte_en=0: the write is a no-op in RAM but still completes through DONE (done pulse, no oor).
- hpb_wr_req dropping while in PEND: the write still completes using the captured tuple.
- Reset mid-operation:
  - The pending write is abandoned and no done pulse is produced.
  - hpb still holds its request, so the write is re-captured from IDLE after reset.
- Minimum write turnaround on an idle read path: IDLE -> PEND -> DONE, so the done pulse comes 2 cycles after req is seen.

Optional Feature:
- Macro RCB_WR_FORCE_EN.
- When defined:
  - A stall counter increments each cycle spent in PEND with the write blocked by a read. It clears on leaving PEND.
  - When the count reaches MAX_WR_STALL, lkp_rd_ready=0 for exactly 1 cycle. The write issues in that cycle and the requester must hold its read.
  - lkp_rd_ready is 1 in all other cycles.
- When undefined:
  - Reads have strict priority and lkp_rd_ready is tied to 1.
  - Continuous reads can starve writes indefinitely.

Test Plan:
- Reads idle; req=1, addr=5, data=64'hDEAD_BEEF_0123_4567, byte_en=8'hFF -> rcb_wr_done pulses 2 cycles later. A read of addr 5 on the following cycle returns that data with valid 1 cycle later.
- Word 7 preloaded with all-ones; write addr 7, data=0, byte_en=8'h0F -> reading addr 7 returns 64'hFFFF_FFFF_0000_0000.
- req held with addr 3, data A for 10 cycles -> exactly one done pulse. Data changes to B while req stays high -> a second done pulse, and addr 3 reads B.
- Write to addr=DEPTH+2 -> done and oor pulse together; a read of addr 2 is unchanged.
- Continuous reads every cycle with a write pending:
  - With RCB_WR_FORCE_EN, ready drops once after 16 stalled cycles, then done pulses.
  - Without it, no done pulse until reads stop.
- Reset asserted while in PEND -> outputs return to reset values immediately and no done pulse. After release with req still high, the write completes normally.
